sr_multicycle: RTL and testbench

- Multicycle right-shift unit for the processor datapath; executes SRL/SRA/SRLV/SRAV one bit position per clock.
- Counterpart to the combinational left-shift helpers: moves data toward the LSB.
- Sits beside the ALU, is started by the multicycle controller, and stalls the controller via busy until done.

---
 rtl/shift_pkg.sv | 9 +
 rtl/sr1_step.sv | 21 ++
 rtl/sr_multicycle.sv | 79 +++++++
 tb/tb_sr_multicycle.sv | 129 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared state type and default widths for the multicycle shifter
package shift_pkg;

    localparam int BITLENGTH_DEF = 32;
    localparam int SHAMTW_DEF    = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sr_state_t;

endpackage

// File: rtl/sr1_step.sv
// sr1_step: one-position shift toward the LSB with fill bit (left mode under SR_MULTICYCLE_LEFT_EN)
module sr1_step
    import shift_pkg::*;
#(
    parameter int BITLENGTH = BITLENGTH_DEF
) (
    input  logic [BITLENGTH-1:0] d,
    input  logic                 fill,
`ifdef SR_MULTICYCLE_LEFT_EN
    input  logic                 left,
`endif
    output logic [BITLENGTH-1:0] q
);

`ifdef SR_MULTICYCLE_LEFT_EN
    assign q = left ? {d[BITLENGTH-2:0], 1'b0} : {fill, d[BITLENGTH-1:1]};
`else
    assign q = {fill, d[BITLENGTH-1:1]};
`endif

endmodule

// File: rtl/sr_multicycle.sv
// sr_multicycle: one bit per clock SRL/SRA unit; SR_MULTICYCLE_LEFT_EN adds SLL via the left port
module sr_multicycle
    import shift_pkg::*;
#(
    parameter int BITLENGTH = BITLENGTH_DEF,
    parameter int SHAMTW    = SHAMTW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITLENGTH-1:0] a,
    input  logic [SHAMTW-1:0]    shamt,
    input  logic                 arith,
`ifdef SR_MULTICYCLE_LEFT_EN
    input  logic                 left,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [BITLENGTH-1:0] y
);

    sr_state_t             state, state_nxt;
    logic [SHAMTW-1:0]     cnt;
    logic                  fill;
    logic [BITLENGTH-1:0]  y_step;
`ifdef SR_MULTICYCLE_LEFT_EN
    logic                  left_q;
`endif

    sr1_step #(.BITLENGTH(BITLENGTH)) u_step (
        .d   (y),
        .fill(fill),
`ifdef SR_MULTICYCLE_LEFT_EN
        .left(left_q),
`endif
        .q   (y_step)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and handshake outputs; start only matters in IDLE
    always_comb begin
        state_nxt = state;
        busy      = state != IDLE;
        done      = state == DONE;
        case (state)
            IDLE:    if (start) state_nxt = (shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt == SHAMTW'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture on accept, then one step per SHIFT cycle; y holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            y    <= '0;
            cnt  <= '0;
            fill <= 1'b0;
`ifdef SR_MULTICYCLE_LEFT_EN
            left_q <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            y    <= a;
            cnt  <= shamt;
            fill <= arith & a[BITLENGTH-1];
`ifdef SR_MULTICYCLE_LEFT_EN
            left_q <= left;
`endif
        end else if (state == SHIFT) begin
            y   <= y_step;
            cnt <= cnt - SHAMTW'(1);
        end
    end

endmodule

// File: tb/tb_sr_multicycle.sv
// tb_sr_multicycle: randomized bench for sr_multicycle against an arithmetic shift model
module tb_sr_multicycle;

    logic        clk = 1'b0;
    logic        reset, start, arith, left;
    logic [31:0] a, y;
    logic [4:0]  shamt;
    logic        busy, done;
    int          n_tests = 0;
    int          n_fail  = 0;

    sr_multicycle dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .a    (a),
        .shamt(shamt),
        .arith(arith),
`ifdef SR_MULTICYCLE_LEFT_EN
        .left (left),
`endif
        .busy (busy),
        .done (done),
        .y    (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] av, input int sv, input logic ar, input logic lf);
        if (lf) return av << sv;
        if (ar) return 32'($signed(av) >>> sv);
        return av >> sv;
    endfunction

    task automatic run_op(input logic [31:0] av, input logic [4:0] sv, input logic ar, input logic lf, input bit hold);
        logic [31:0] expv;
        int lat;
        expv  = model(av, int'(sv), ar, lf);
        a     = av;
        shamt = sv;
        arith = ar;
        left  = lf;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        a     = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
        left  = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat <= 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(sv) + 32'd1);
        chk("result", y, expv);
        for (int i = 0; i < (hold ? 1 : 3); i++) begin
            @(posedge clk); #1;
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("y_hold", y, expv);
        end
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; a = '0; shamt = '0; arith = 1'b0; left = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", y, 32'd0);
        reset = 1'b0;
        a = 32'h8000_0000; shamt = 5'd20; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_y", y, 32'd0);
        pulses = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        run_op(32'hF000_000F, 5'd4, 1'b0, 1'b0, 1'b0);
        chk("srl_const", y, 32'h0F00_0000);
        run_op(32'h8000_0010, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("sra_const", y, 32'hF800_0001);
        run_op(32'h8000_0010, 5'd31, 1'b1, 1'b0, 1'b0);
        chk("sra31_const", y, 32'hFFFF_FFFF);
        run_op(32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("zero_const", y, 32'h1234_5678);
        run_op(32'h8765_4321, 5'd7, 1'b1, 1'b0, 1'b1);
        run_op(32'h0F0F_F0F0, 5'd3, 1'b0, 1'b0, 1'b1);
        run_op(32'hC000_0001, 5'd0, 1'b1, 1'b0, 1'b1);
        run_op(32'h8000_0001, 5'd31, 1'b0, 1'b0, 1'b0);
`ifdef SR_MULTICYCLE_LEFT_EN
        run_op(32'h0000_0001, 5'd31, 1'b0, 1'b1, 1'b0);
        chk("sll31_const", y, 32'h8000_0000);
`endif
        for (int k = 0; k < 30; k++) begin
            logic lf;
`ifdef SR_MULTICYCLE_LEFT_EN
            lf = 1'($urandom);
`else
            lf = 1'b0;
`endif
            run_op($urandom, 5'($urandom), 1'($urandom), lf, 1'($urandom));
        end
        start = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
